pixel_mixer: RTL and testbench

- Sits directly upstream of the row RAM double buffer in the PPU logic.
- Once per scanline, it walks the pixel positions of the background tile row, the foreground tile row and the sprite row buffers, and resolves layer priority and transparency per pixel.
- It writes the winning 10-bit pixel code into the back row RAM through the pmxr_rowram_* write port, which the HDMI output reads after the next swap.

---
 rtl/ppu_pkg.sv | 34 +++
 rtl/pixel_mixer_if.sv | 31 +++
 rtl/pixel_prio_resolve.sv | 46 ++++
 rtl/pixel_mixer.sv | 109 ++++++++++
 tb/tb_pixel_mixer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants: pixel code layout, sprite priority levels,
// layer-enable bit positions and the mixer state encoding.
package ppu_pkg;

    localparam int ROW_WIDTH_DEFAULT = 320;
    localparam int PIX_W_DEFAULT     = 10;

    localparam int LAYER_BG  = 0;
    localparam int LAYER_FG  = 1;
    localparam int LAYER_SPR = 2;

    typedef struct packed {
        logic [5:0] palette;
        logic [3:0] colour;
    } pix_code_t;

    typedef enum logic [1:0] {
        SPR_BEHIND_BG = 2'd0,
        SPR_BEHIND_FG = 2'd1,
        SPR_FRONT     = 2'd2
    } spr_prio_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } mix_state_e;

    // Colour index 0 is the transparent key on every layer.
    function automatic logic is_opaque(input logic [3:0] colour, input logic enable);
        return enable && (colour != 4'd0);
    endfunction

endpackage

// File: rtl/pixel_mixer_if.sv
// Control, layer-read and row-RAM-write signals of the scanline pixel mixer.
interface pixel_mixer_if
    import ppu_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT
);
    logic             mix_start;
    logic             mix_busy;
    logic             mix_done;
    logic [2:0]       layer_en;
    logic [8:0]       layer_rdaddr;
    logic [PIX_W-1:0] bg_rddata;
    logic [PIX_W-1:0] fg_rddata;
    logic [PIX_W-1:0] spr_rddata;
    logic [1:0]       spr_prio;
    logic [PIX_W-1:0] pmxr_rowram_wrdata;
    logic [8:0]       pmxr_rowram_wraddr;
    logic             pmxr_rowram_wren;

    modport slave (
        input  mix_start, layer_en, bg_rddata, fg_rddata, spr_rddata, spr_prio,
        output mix_busy, mix_done, layer_rdaddr,
               pmxr_rowram_wrdata, pmxr_rowram_wraddr, pmxr_rowram_wren
    );

    modport master (
        output mix_start, layer_en, bg_rddata, fg_rddata, spr_rddata, spr_prio,
        input  mix_busy, mix_done, layer_rdaddr,
               pmxr_rowram_wrdata, pmxr_rowram_wraddr, pmxr_rowram_wren
    );
endinterface

// File: rtl/pixel_prio_resolve.sv
// Combinational per-pixel layer resolve: first opaque layer in the order
// selected by the sprite priority wins, otherwise the backdrop code 0.
module pixel_prio_resolve
    import ppu_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT
)
(
    input  logic [PIX_W-1:0] bg_code,
    input  logic [PIX_W-1:0] fg_code,
    input  logic [PIX_W-1:0] spr_code,
    input  logic [1:0]       spr_prio,
    input  logic [2:0]       layer_en,
    output logic [PIX_W-1:0] pix_out
);

    logic bg_op;
    logic fg_op;
    logic spr_op;

    always_comb begin
        bg_op   = is_opaque(bg_code[3:0],  layer_en[LAYER_BG]);
        fg_op   = is_opaque(fg_code[3:0],  layer_en[LAYER_FG]);
        spr_op  = is_opaque(spr_code[3:0], layer_en[LAYER_SPR]);
        pix_out = '0;
        case (spr_prio)
            SPR_BEHIND_BG: begin
                if (fg_op)       pix_out = fg_code;
                else if (bg_op)  pix_out = bg_code;
                else if (spr_op) pix_out = spr_code;
            end
            SPR_BEHIND_FG: begin
                if (fg_op)       pix_out = fg_code;
                else if (spr_op) pix_out = spr_code;
                else if (bg_op)  pix_out = bg_code;
            end
            // Priority 3 behaves like SPR_FRONT.
            default: begin
                if (spr_op)      pix_out = spr_code;
                else if (fg_op)  pix_out = fg_code;
                else if (bg_op)  pix_out = bg_code;
            end
        endcase
    end

endmodule

// File: rtl/pixel_mixer.sv
// Scanline pixel mixer: sweeps the layer row buffers, resolves each pixel and
// writes it into the back row RAM through a fixed two-stage pipeline.
module pixel_mixer
    import ppu_pkg::*;
#(
    parameter int ROW_WIDTH = ROW_WIDTH_DEFAULT,
    parameter int PIX_W     = PIX_W_DEFAULT
)
(
    input logic          clk,
    input logic          rst,
    pixel_mixer_if.slave bus
);

    localparam logic [8:0] LAST_X = 9'(ROW_WIDTH - 1);

    mix_state_e       state_q, state_d;
    logic [8:0]       rdaddr_q, rdaddr_d;
    logic [2:0]       en_q, en_d;
    logic             busy_q, busy_d;
    logic             s1_valid_q, s1_valid_d;
    logic [8:0]       s1_x_q, s1_x_d;
    logic             wren_q, wren_d;
    logic [8:0]       wraddr_q, wraddr_d;
    logic [PIX_W-1:0] wrdata_q, wrdata_d;
    logic             done_q, done_d;
    logic [PIX_W-1:0] pix_resolved;

    pixel_prio_resolve #(.PIX_W(PIX_W)) u_resolve (
        .bg_code  (bus.bg_rddata),
        .fg_code  (bus.fg_rddata),
        .spr_code (bus.spr_rddata),
        .spr_prio (bus.spr_prio),
        .layer_en (en_q),
        .pix_out  (pix_resolved)
    );

    // Stage 1 tracks which x the returning read data belongs to; stage 2 is the write.
    always_comb begin
        state_d    = state_q;
        rdaddr_d   = rdaddr_q;
        en_d       = en_q;
        busy_d     = busy_q;
        s1_valid_d = 1'b0;
        s1_x_d     = s1_x_q;
        wren_d     = s1_valid_q;
        wraddr_d   = s1_valid_q ? s1_x_q : wraddr_q;
        wrdata_d   = s1_valid_q ? pix_resolved : wrdata_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mix_start) begin
                    state_d  = ST_RUN;
                    rdaddr_d = 9'd0;
                    en_d     = bus.layer_en;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                s1_valid_d = 1'b1;
                s1_x_d     = rdaddr_q;
                if (rdaddr_q == LAST_X) state_d = ST_DRAIN;
                else                    rdaddr_d = rdaddr_q + 9'd1;
            end
            ST_DRAIN: begin
                if (s1_valid_q && s1_x_q == LAST_X) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdaddr_q   <= '0;
            en_q       <= '0;
            busy_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdaddr_q   <= rdaddr_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            wren_q     <= wren_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
            done_q     <= done_d;
        end
    end

    assign bus.mix_busy           = busy_q;
    assign bus.mix_done           = done_q;
    assign bus.layer_rdaddr       = rdaddr_q;
    assign bus.pmxr_rowram_wren   = wren_q;
    assign bus.pmxr_rowram_wraddr = wraddr_q;
    assign bus.pmxr_rowram_wrdata = wrdata_q;

endmodule

// File: tb/tb_pixel_mixer.sv
// Directed bench for pixel_mixer: layer row buffers modelled as 1-cycle RAMs,
// row RAM writes captured per scanline and compared against hand-derived codes.
module tb_pixel_mixer;

    localparam int RW = 320;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pixel_mixer_if #(.PIX_W(10)) bus ();

    pixel_mixer #(.ROW_WIDTH(RW), .PIX_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [9:0] bg_mem   [0:511];
    logic [9:0] fg_mem   [0:511];
    logic [9:0] spr_mem  [0:511];
    logic [1:0] prio_mem [0:511];

    always @(posedge clk) begin
        bus.bg_rddata  <= bg_mem[bus.layer_rdaddr];
        bus.fg_rddata  <= fg_mem[bus.layer_rdaddr];
        bus.spr_rddata <= spr_mem[bus.layer_rdaddr];
        bus.spr_prio   <= prio_mem[bus.layer_rdaddr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] wa_log [$];
    logic [9:0] wd_log [$];
    int done_cnt, done_addr, done_wren, busy_cnt, first_rd, first_wr, timed_out;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fill_layers(input logic [9:0] bg, input logic [9:0] fg,
                               input logic [9:0] spr, input logic [1:0] prio);
        for (int i = 0; i < 512; i++) begin
            bg_mem[i]   = bg;
            fg_mem[i]   = fg;
            spr_mem[i]  = spr;
            prio_mem[i] = prio;
        end
    endtask

    // Pulses mix_start and logs every write until mix_done plus post_cycles.
    task automatic capture_scan(input int extra_start_at, input int post_cycles);
        int cyc;
        int after;
        bit seen_done;
        wa_log.delete();
        wd_log.delete();
        done_cnt = 0; done_addr = -1; done_wren = 0; busy_cnt = 0;
        first_rd = -1; first_wr = -1; timed_out = 0;
        seen_done = 0; after = 0;
        @(negedge clk); bus.mix_start = 1'b1;
        @(negedge clk); bus.mix_start = 1'b0;
        cyc = 1;
        while (1) begin
            if (bus.mix_busy) busy_cnt++;
            if (bus.mix_busy && bus.layer_rdaddr == 9'd0 && first_rd < 0) first_rd = cyc;
            if (bus.pmxr_rowram_wren) begin
                wa_log.push_back(bus.pmxr_rowram_wraddr);
                wd_log.push_back(bus.pmxr_rowram_wrdata);
                if (first_wr < 0) first_wr = cyc;
            end
            if (bus.mix_done) begin
                done_cnt++;
                done_addr = int'(bus.pmxr_rowram_wraddr);
                done_wren = int'(bus.pmxr_rowram_wren);
                seen_done = 1;
            end
            if (seen_done) begin
                if (after >= post_cycles) break;
                after++;
            end
            if (cyc >= 1000) begin
                timed_out = 1;
                break;
            end
            bus.mix_start = (cyc == extra_start_at);
            @(negedge clk);
            cyc++;
        end
        bus.mix_start = 1'b0;
    endtask

    task automatic test_reset();
        int n_wr, n_busy, n_done;
        rst = 1'b1;
        bus.mix_start = 1'b0;
        bus.layer_en = 3'b111;
        fill_layers(10'h000, 10'h000, 10'h000, 2'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.layer_rdaddr !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_rdaddr: got %0h expected 0", bus.layer_rdaddr); end
        n_checks++; if (bus.pmxr_rowram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wren: got %b expected 0", bus.pmxr_rowram_wren); end
        n_checks++; if (bus.mix_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.mix_busy); end
        n_checks++; if (bus.mix_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus.mix_done); end
        n_checks++; if (bus.pmxr_rowram_wraddr !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_wraddr: got %0h expected 0", bus.pmxr_rowram_wraddr); end
        n_checks++; if (bus.pmxr_rowram_wrdata !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_wrdata: got %0h expected 0", bus.pmxr_rowram_wrdata); end
        n_wr = 0; n_busy = 0; n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.pmxr_rowram_wren !== 1'b0) n_wr++;
            if (bus.mix_busy !== 1'b0) n_busy++;
            if (bus.mix_done !== 1'b0) n_done++;
        end
        n_checks++; if (n_wr != 0) begin n_fail++; $display("[TB] FAIL idle_wren: got %0d cycles expected 0", n_wr); end
        n_checks++; if (n_busy != 0) begin n_fail++; $display("[TB] FAIL idle_busy: got %0d cycles expected 0", n_busy); end
        n_checks++; if (n_done != 0) begin n_fail++; $display("[TB] FAIL idle_done: got %0d cycles expected 0", n_done); end
    endtask

    task automatic test_full_scanline();
        int addr_err, data_err;
        fill_layers(10'h011, 10'h000, 10'h000, 2'd2);
        bus.layer_en = 3'b111;
        capture_scan(-1, 4);
        addr_err = 0; data_err = 0;
        foreach (wa_log[i]) begin
            if (wa_log[i] !== 9'(i)) addr_err++;
            if (wd_log[i] !== 10'h011) data_err++;
        end
        n_checks++; if (timed_out != 0) begin n_fail++; $display("[TB] FAIL full_timeout: got %0d expected 0", timed_out); end
        n_checks++; if (wa_log.size() != RW) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected %0d", wa_log.size(), RW); end
        n_checks++; if (addr_err != 0) begin n_fail++; $display("[TB] FAIL full_addr: got %0d bad expected 0", addr_err); end
        n_checks++; if (data_err != 0) begin n_fail++; $display("[TB] FAIL full_data: got %0d bad expected 0", data_err); end
        n_checks++; if (first_rd != 1) begin n_fail++; $display("[TB] FAIL full_first_rd: got %0d expected 1", first_rd); end
        n_checks++; if (first_wr - first_rd != 2) begin n_fail++; $display("[TB] FAIL full_latency: got %0d expected 2", first_wr - first_rd); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL full_done_cnt: got %0d expected 1", done_cnt); end
        n_checks++; if (done_addr != RW - 1 || done_wren != 1) begin n_fail++; $display("[TB] FAIL full_done_addr: got %0d/%0d expected %0d/1", done_addr, done_wren, RW - 1); end
        n_checks++; if (busy_cnt != RW + 1) begin n_fail++; $display("[TB] FAIL full_busy_len: got %0d expected %0d", busy_cnt, RW + 1); end
    endtask

    task automatic test_priority();
        logic [9:0] c_bg  [10] = '{10'h021, 10'h021, 10'h021, 10'h021, 10'h021, 10'h021, 10'h020, 10'h020, 10'h021, 10'h021};
        logic [9:0] c_fg  [10] = '{10'h032, 10'h032, 10'h030, 10'h030, 10'h032, 10'h032, 10'h030, 10'h030, 10'h032, 10'h032};
        logic [9:0] c_spr [10] = '{10'h043, 10'h043, 10'h043, 10'h043, 10'h043, 10'h043, 10'h040, 10'h043, 10'h043, 10'h043};
        logic [1:0] c_pr  [10] = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd3, 2'd3};
        logic [2:0] c_en  [10] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b001};
        logic [9:0] c_exp [10] = '{10'h043, 10'h032, 10'h043, 10'h021, 10'h043, 10'h032, 10'h000, 10'h043, 10'h032, 10'h021};
        logic [9:0] got;
        for (int k = 0; k < 10; k++) begin
            fill_layers(10'h000, 10'h000, 10'h000, 2'd0);
            bg_mem[5] = c_bg[k]; fg_mem[5] = c_fg[k]; spr_mem[5] = c_spr[k]; prio_mem[5] = c_pr[k];
            bus.layer_en = c_en[k];
            capture_scan(-1, 0);
            got = (wd_log.size() > 6) ? wd_log[5] : 10'h3FF;
            n_checks++; if (got !== c_exp[k]) begin n_fail++; $display("[TB] FAIL prio_case%0d: got %0h expected %0h", k, got, c_exp[k]); end
            if (k == 0) begin
                got = (wd_log.size() > 6) ? (wd_log[4] | wd_log[6]) : 10'h3FF;
                n_checks++; if (got !== 10'h000) begin n_fail++; $display("[TB] FAIL prio_neighbours: got %0h expected 0", got); end
            end
        end
    endtask

    task automatic test_layer_enables();
        logic [2:0] e_en  [4] = '{3'b001, 3'b000, 3'b010, 3'b110};
        logic [9:0] e_exp [4] = '{10'h011, 10'h000, 10'h055, 10'h066};
        int bad;
        fill_layers(10'h011, 10'h055, 10'h066, 2'd2);
        for (int k = 0; k < 4; k++) begin
            bus.layer_en = e_en[k];
            capture_scan(-1, 0);
            bad = (wd_log.size() == RW) ? 0 : 1000;
            foreach (wd_log[i]) if (wd_log[i] !== e_exp[k]) bad++;
            n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL enable_%b: got %0d bad writes expected 0 (all %0h)", e_en[k], bad, e_exp[k]); end
        end
    endtask

    task automatic test_start_while_busy();
        int addr_err;
        fill_layers(10'h011, 10'h000, 10'h000, 2'd0);
        bus.layer_en = 3'b111;
        capture_scan(100, 10);
        addr_err = 0;
        foreach (wa_log[i]) if (wa_log[i] !== 9'(i)) addr_err++;
        n_checks++; if (wa_log.size() != RW) begin n_fail++; $display("[TB] FAIL busy_start_count: got %0d expected %0d", wa_log.size(), RW); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL busy_start_done: got %0d expected 1", done_cnt); end
        n_checks++; if (addr_err != 0) begin n_fail++; $display("[TB] FAIL busy_start_addr: got %0d bad expected 0", addr_err); end
    endtask

    task automatic test_back_to_back();
        int addr_err, data_err;
        fill_layers(10'h011, 10'h000, 10'h000, 2'd0);
        bus.layer_en = 3'b111;
        capture_scan(-1, 0);
        fill_layers(10'h022, 10'h000, 10'h000, 2'd0);
        capture_scan(-1, 4);
        addr_err = 0; data_err = 0;
        foreach (wa_log[i]) begin
            if (wa_log[i] !== 9'(i)) addr_err++;
            if (wd_log[i] !== 10'h022) data_err++;
        end
        n_checks++; if (first_rd != 1) begin n_fail++; $display("[TB] FAIL b2b_accept: got %0d expected 1", first_rd); end
        n_checks++; if (wa_log.size() != RW) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected %0d", wa_log.size(), RW); end
        n_checks++; if (addr_err != 0 || data_err != 0) begin n_fail++; $display("[TB] FAIL b2b_content: got %0d/%0d bad expected 0/0", addr_err, data_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL b2b_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int found, n_wr, n_done, addr_err;
        fill_layers(10'h011, 10'h000, 10'h000, 2'd0);
        bus.layer_en = 3'b111;
        @(negedge clk); bus.mix_start = 1'b1;
        @(negedge clk); bus.mix_start = 1'b0;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.layer_rdaddr == 9'd150) begin found = 1; break; end
            @(negedge clk);
        end
        n_checks++; if (found != 1) begin n_fail++; $display("[TB] FAIL mid_reach150: got %0d expected 1", found); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.pmxr_rowram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_wren: got %b expected 0", bus.pmxr_rowram_wren); end
        n_checks++; if (bus.mix_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %b expected 0", bus.mix_busy); end
        n_wr = 0; n_done = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.pmxr_rowram_wren !== 1'b0) n_wr++;
            if (bus.mix_done !== 1'b0) n_done++;
            @(negedge clk);
        end
        n_checks++; if (n_wr != 0 || n_done != 0) begin n_fail++; $display("[TB] FAIL mid_quiet: got %0d writes %0d done expected 0/0", n_wr, n_done); end
        capture_scan(-1, 4);
        addr_err = 0;
        foreach (wa_log[i]) if (wa_log[i] !== 9'(i)) addr_err++;
        n_checks++; if (wa_log.size() != RW || addr_err != 0) begin n_fail++; $display("[TB] FAIL mid_restart: got %0d writes %0d bad expected %0d/0", wa_log.size(), addr_err, RW); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL mid_restart_done: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus.mix_start = 1'b0;
        bus.layer_en = 3'b000;
        test_reset();
        test_full_scanline();
        test_priority();
        test_layer_enables();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
